// File: rtl/link_fifo_rd_sched_if.sv
// Link FIFO read-side bundle between the rd_clk scheduler and its neighbours.
//   fifo_rd_en / fifo_rd_data / fifo_rd_empty / fifo_almost_empty : async FIFO read port
//   m_data / m_valid / m_ready / m_is_idle                         : block stream to TX gearbox
// master = scheduler view, slave = FIFO + gearbox view.
interface link_fifo_rd_sched_if #(
    parameter int DATA_W = 66
);
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_empty;
    logic              fifo_almost_empty;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_is_idle;

    modport master (
        output fifo_rd_en, m_data, m_valid, m_is_idle,
        input  fifo_rd_data, fifo_rd_empty, fifo_almost_empty, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_data, m_valid, m_is_idle,
        output fifo_rd_data, fifo_rd_empty, fifo_almost_empty, m_ready
    );
endinterface

// File: rtl/link_fifo_rd_sched.sv
// Read-side scheduler for the 66-bit async link FIFO (rd_clk domain).
// Issues FIFO reads against a credit budget, absorbs the fixed FIFO read
// latency in a small skid buffer and streams blocks to the TX gearbox.
// Streaming starts once the FIFO is past almost-empty, or after START_TMO
// cycles of waiting on a non-empty FIFO.
// Ports:
//   rd_clk, rd_rst   clock, async active-high reset
//   enable           stream enable (level)
//   lnk              FIFO read port + output block stream (master modport)
//   state            0 IDLE, 1 WAIT_FILL, 2 STREAM
//   underrun_cnt     saturating count of STREAM cycles with m_ready and no data
// Optional: define LINK_FIFO_RD_SCHED_IDLE_INSERT_EN to emit IDLE_BLOCK on underrun.
module link_fifo_rd_sched #(
    parameter int                DATA_W     = 66,
    parameter int                RD_LAT     = 1,
    parameter int                BUF_DEPTH  = 4,
    parameter int                START_TMO  = 64,
    parameter logic [DATA_W-1:0] IDLE_BLOCK = 66'h1_0000_0000_0000_001E
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 enable,
    link_fifo_rd_sched_if.master lnk,
    output logic [1:0]           state,
    output logic [15:0]          underrun_cnt
);
    localparam int PTR_W  = $clog2(BUF_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (START_TMO > 1) ? $clog2(START_TMO) : 1;
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(START_TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t            st, st_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [RD_LAT:1]   vld_pipe;
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  buf_count, inflight;
    logic [CNT_W:0]    used;
    logic              rd_en, push, pop;

    assign state = st;

    // Credit counts both buffered and in-flight words, so the buffer can
    // never be asked to take more than it holds.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= RD_LAT; i++)
            inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    assign used  = {1'b0, buf_count} + {1'b0, inflight};
    assign rd_en = (st == S_STREAM) & enable & ~lnk.fifo_rd_empty
                 & (used < (CNT_W+1)'(BUF_DEPTH));
    assign lnk.fifo_rd_en = rd_en;

    // Returning words are always captured, even after enable drops.
    assign push = vld_pipe[RD_LAT];
    assign pop  = (buf_count != '0) & lnk.m_ready;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            st       <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            st       <= st_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    always_comb begin
        st_nxt   = st;
        wait_nxt = wait_cnt;
        case (st)
            S_IDLE: begin
                wait_nxt = '0;
                if (enable) st_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt != TMO_LAST) wait_nxt = wait_cnt + 1'b1;
                if (!enable)
                    st_nxt = S_IDLE;
                else if (!lnk.fifo_almost_empty ||
                         (wait_cnt == TMO_LAST && !lnk.fifo_rd_empty))
                    st_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (!enable) st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_en;
            for (int i = 2; i <= RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            for (int i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= lnk.fifo_rd_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   buf_count <= buf_count + 1'b1;
                2'b01:   buf_count <= buf_count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        lnk.m_valid   = (buf_count != '0);
        lnk.m_data    = (buf_count != '0) ? mem[rd_ptr] : '0;
        lnk.m_is_idle = 1'b0;
`ifdef LINK_FIFO_RD_SCHED_IDLE_INSERT_EN
        // Idle fill is not a buffer entry; it is never popped.
        if (st == S_STREAM && buf_count == '0) begin
            lnk.m_valid   = 1'b1;
            lnk.m_data    = IDLE_BLOCK;
            lnk.m_is_idle = 1'b1;
        end
`endif
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst)
            underrun_cnt <= '0;
        else if (st == S_STREAM && lnk.m_ready && buf_count == '0 &&
                 underrun_cnt != 16'hFFFF)
            underrun_cnt <= underrun_cnt + 16'd1;
    end

    a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
        !(push && !pop && buf_count == CNT_W'(BUF_DEPTH)));
endmodule

// File: tb/tb_link_fifo_rd_sched.sv
// Self-checking bench for link_fifo_rd_sched: a queue-indexed FIFO model with
// fixed read latency feeds the DUT; delivered blocks are collected and compared
// against load order, with timing rules computed from the cycle counter.
module tb_link_fifo_rd_sched;
    localparam int DATA_W    = 66;
    localparam int RD_LAT    = 2;
    localparam int BUF_DEPTH = 4;
    localparam int START_TMO = 64;
    localparam int AE_MARK   = 4;
    localparam logic [DATA_W-1:0] IDLE_BLK = 66'h1_0000_0000_0000_001E;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  state;
    logic [15:0] underrun_cnt;

    link_fifo_rd_sched_if #(.DATA_W(DATA_W)) lnk ();

    link_fifo_rd_sched #(
        .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH),
        .START_TMO(START_TMO), .IDLE_BLOCK(IDLE_BLK)
    ) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .enable(enable), .lnk(lnk),
        .state(state), .underrun_cnt(underrun_cnt)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: wr_idx owned by stimulus, rd_idx by the read port.
    logic [DATA_W-1:0] fifo_mem [0:1023];
    logic [DATA_W-1:0] pipe [RD_LAT];
    int wr_idx = 0;
    int rd_idx = 0;

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_idx <= wr_idx;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            if (lnk.fifo_rd_en) begin
                pipe[0] <= fifo_mem[rd_idx];
                rd_idx  <= rd_idx + 1;
            end else begin
                pipe[0] <= {2'b11, $urandom(), $urandom()};
            end
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign lnk.fifo_rd_data      = pipe[RD_LAT-1];
    assign lnk.fifo_rd_empty     = (wr_idx == rd_idx);
    assign lnk.fifo_almost_empty = ((wr_idx - rd_idx) < AE_MARK);

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int base  = 0;
    logic [DATA_W-1:0] got [$];

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_idx] = {2'($urandom_range(1, 2)), $urandom(), $urandom()};
            wr_idx++;
        end
    endtask

    // Drive m_ready for one cycle, record an accepted real block, advance.
    task automatic step(input logic rdy);
        lnk.m_ready = rdy;
        if (lnk.m_valid && rdy && !lnk.m_is_idle) got.push_back(lnk.m_data);
        @(negedge rd_clk);
        cyc++;
    endtask

    task automatic drain();
        enable = 1'b0;
        repeat (12) step(1'b1);
    endtask

    task automatic test_reset();
        rd_rst = 1'b1;
        step(1'b1);
        step(1'b1);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++; if (lnk.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%0b exp=0", lnk.fifo_rd_en); end
        total++; if (lnk.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%0b exp=0", lnk.m_valid); end
        total++; if (lnk.m_data !== '0) begin bad++; $display("FAIL rst_m_data got=%0h exp=0", lnk.m_data); end
        total++; if (lnk.m_is_idle !== 1'b0) begin bad++; $display("FAIL rst_m_is_idle got=%0b exp=0", lnk.m_is_idle); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL rst_underrun got=%0d exp=0", underrun_cnt); end
        rd_rst = 1'b0;
        step(1'b1);
        base = wr_idx;
        got.delete();
        load(10);
        repeat (5) step(1'b1);
        total++;
        if ({state, lnk.fifo_rd_en, lnk.m_valid} !== 4'b0) begin
            bad++; $display("FAIL idle_hold got=%0h exp=0", {state, lnk.fifo_rd_en, lnk.m_valid});
        end
    endtask

    // Uses the 10 blocks loaded by test_reset.
    task automatic test_stream();
        int t_wf = -1, t_st = -1, t_v = -1, t_last = -1;
        int c0 = cyc;
        int u0 = int'(underrun_cnt);
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1'b1);
            if (state == 2'd1 && t_wf < 0) t_wf = cyc;
            if (state == 2'd2 && t_st < 0) t_st = cyc;
            if (lnk.m_valid && !lnk.m_is_idle) begin
                if (t_v < 0) t_v = cyc;
                t_last = cyc;
            end
        end
        total++; if (t_wf != c0 + 1) begin bad++; $display("FAIL wait_entry got=%0d exp=%0d", t_wf, c0 + 1); end
        total++; if (t_st != t_wf + 1) begin bad++; $display("FAIL stream_entry got=%0d exp=%0d", t_st, t_wf + 1); end
        total++; if (t_v - t_st != RD_LAT + 1) begin bad++; $display("FAIL first_latency got=%0d exp=%0d", t_v - t_st, RD_LAT + 1); end
        total++; if (t_last - t_v != 9) begin bad++; $display("FAIL b2b_span got=%0d exp=9", t_last - t_v); end
        total++; if (got.size() != 10) begin bad++; $display("FAIL stream_count got=%0d exp=10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            total++;
            if (got[i] !== fifo_mem[base + i]) begin bad++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, got[i], fifo_mem[base + i]); end
        end
        total++;
        if (int'(underrun_cnt) - u0 != (cyc - t_st) - 10) begin
            bad++; $display("FAIL stream_underrun got=%0d exp=%0d", int'(underrun_cnt) - u0, (cyc - t_st) - 10);
        end
        drain();
    endtask

    task automatic test_timeout();
        int t_wf = -1, t_st = -1;
        base = wr_idx;
        got.delete();
        load(2);
        enable = 1'b1;
        for (int i = 0; i < 90; i++) begin
            step(1'b1);
            if (state == 2'd1 && t_wf < 0) t_wf = cyc;
            if (state == 2'd2 && t_st < 0) t_st = cyc;
        end
        total++; if (t_st - t_wf != START_TMO) begin bad++; $display("FAIL tmo_start got=%0d exp=%0d", t_st - t_wf, START_TMO); end
        total++; if (got.size() != 2) begin bad++; $display("FAIL tmo_count got=%0d exp=2", got.size()); end
        for (int i = 0; i < got.size() && i < 2; i++) begin
            total++;
            if (got[i] !== fifo_mem[base + i]) begin bad++; $display("FAIL tmo_data[%0d] got=%0h exp=%0h", i, got[i], fifo_mem[base + i]); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int loaded = 0;
        int i = 0;
        logic rdy, held_v;
        logic [DATA_W-1:0] held;
        base = wr_idx;
        got.delete();
        enable = 1'b1;
        while (got.size() < 40 && i < 600) begin
            if (loaded < 40 && $urandom_range(0, 3) != 0) begin load(1); loaded++; end
            rdy    = (i < 80) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
            held_v = lnk.m_valid && !lnk.m_is_idle && !rdy;
            held   = lnk.m_data;
            step(rdy);
            if (held_v) begin
                total++;
                if (lnk.m_valid !== 1'b1 || lnk.m_data !== held) begin
                    bad++; $display("FAIL stall_hold got=%0h exp=%0h", lnk.m_data, held);
                end
            end
            i++;
        end
        total++; if (got.size() != 40) begin bad++; $display("FAIL bp_count got=%0d exp=40", got.size()); end
        for (int k = 0; k < got.size() && k < 40; k++) begin
            total++;
            if (got[k] !== fifo_mem[base + k]) begin bad++; $display("FAIL bp_data[%0d] got=%0h exp=%0h", k, got[k], fifo_mem[base + k]); end
        end
        drain();
        total++; if (got.size() != 40) begin bad++; $display("FAIL bp_extra got=%0d exp=40", got.size()); end
    endtask

    task automatic test_underrun();
        int u0;
        logic exp_v, exp_idle;
`ifdef LINK_FIFO_RD_SCHED_IDLE_INSERT_EN
        exp_v = 1'b1; exp_idle = 1'b1;
`else
        exp_v = 1'b0; exp_idle = 1'b0;
`endif
        base = wr_idx;
        got.delete();
        load(4);
        enable = 1'b1;
        repeat (14) step(1'b0);
        u0 = int'(underrun_cnt);
        for (int i = 0; i < 9; i++) begin
            if (i >= 4) begin
                total++;
                if ({lnk.m_valid, lnk.m_is_idle} !== {exp_v, exp_idle}) begin
                    bad++; $display("FAIL ur_flags[%0d] got=%0b exp=%0b", i, {lnk.m_valid, lnk.m_is_idle}, {exp_v, exp_idle});
                end
                if (exp_idle) begin
                    total++;
                    if (lnk.m_data !== IDLE_BLK) begin bad++; $display("FAIL ur_idle_data got=%0h exp=%0h", lnk.m_data, IDLE_BLK); end
                end
            end
            step(1'b1);
        end
        step(1'b0);
        total++; if (int'(underrun_cnt) - u0 != 5) begin bad++; $display("FAIL ur_count got=%0d exp=5", int'(underrun_cnt) - u0); end
        total++; if (got.size() != 4) begin bad++; $display("FAIL ur_real got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            total++;
            if (got[i] !== fifo_mem[base + i]) begin bad++; $display("FAIL ur_data[%0d] got=%0h exp=%0h", i, got[i], fifo_mem[base + i]); end
        end
        drain();
    endtask

    task automatic test_enable_drop();
        int k = 0;
        int nread;
        base = wr_idx;
        got.delete();
        load(20);
        enable = 1'b1;
        while (state != 2'd2 && k < 10) begin step(1'b1); k++; end
        repeat (6) step(1'b1);
        total++; if (lnk.fifo_rd_en !== 1'b1) begin bad++; $display("FAIL ed_reading got=%0b exp=1", lnk.fifo_rd_en); end
        enable = 1'b0;
        #1;
        total++; if (lnk.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL ed_rd_en_now got=%0b exp=0", lnk.fifo_rd_en); end
        step(1'b1);
        total++; if (state !== 2'd0) begin bad++; $display("FAIL ed_state got=%0d exp=0", state); end
        total++; if (lnk.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL ed_rd_en_next got=%0b exp=0", lnk.fifo_rd_en); end
        nread = rd_idx - base;
        repeat (10) step(1'b1);
        total++; if (rd_idx - base != nread) begin bad++; $display("FAIL ed_no_reads got=%0d exp=%0d", rd_idx - base, nread); end
        total++; if (got.size() != nread) begin bad++; $display("FAIL ed_delivered got=%0d exp=%0d", got.size(), nread); end
        for (int i = 0; i < got.size() && i < nread; i++) begin
            total++;
            if (got[i] !== fifo_mem[base + i]) begin bad++; $display("FAIL ed_data[%0d] got=%0h exp=%0h", i, got[i], fifo_mem[base + i]); end
        end
    endtask

    // FIFO still holds the unread tail of test_enable_drop.
    task automatic test_reset_mid();
        enable = 1'b1;
        repeat (8) step(1'b1);
        repeat (4) step(1'b0);
        #2 rd_rst = 1'b1;
        #1;
        total++; if (lnk.m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got=%0b exp=0", lnk.m_valid); end
        total++; if (lnk.m_data !== '0) begin bad++; $display("FAIL mid_m_data got=%0h exp=0", lnk.m_data); end
        total++; if (lnk.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en got=%0b exp=0", lnk.fifo_rd_en); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL mid_state got=%0d exp=0", state); end
        total++; if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL mid_underrun got=%0d exp=0", underrun_cnt); end
        enable = 1'b0;
        @(negedge rd_clk);
        rd_rst = 1'b0;
        got.delete();
        repeat (6) step(1'b1);
        total++; if (got.size() != 0) begin bad++; $display("FAIL mid_stale got=%0d exp=0", got.size()); end
        enable = 1'b1;
        repeat (10) step(1'b1);
        total++; if (got.size() != 0) begin bad++; $display("FAIL mid_flushed got=%0d exp=0", got.size()); end
        total++; if (state !== 2'd1) begin bad++; $display("FAIL mid_wait got=%0d exp=1", state); end
    endtask

    initial begin
        lnk.m_ready = 1'b1;
        @(negedge rd_clk);
        test_reset();
        test_stream();
        test_timeout();
        test_backpressure();
        test_underrun();
        test_enable_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
